// File: rtl/jshift_seq_pkg.sv
// ============================================================================
//  Module   : jshift_seq_pkg
//  Brief    : Shared encodings and width helpers for the sequential shifter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ARCH_BITS
`define ARCH_BITS 8
`endif

package jshift_seq_pkg;

    localparam logic [1:0] JSH_LOGICAL = 2'b00;
    localparam logic [1:0] JSH_RCARRY  = 2'b01;
    localparam logic [1:0] JSH_ROT     = 2'b10;
    localparam logic [1:0] JSH_ARITH   = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One extra bit so a count of exactly ARCH_BITS is representable.
    function automatic int jsh_cnt_bits(input int arch_bits);
        return $clog2(arch_bits) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jshift_seq_step.sv
// ============================================================================
//  Module   : jshift_step
//  Brief    : Combinational one-bit shift/rotate step (index 0 is the MSB).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module jshift_step
    import jshift_seq_pkg::*;
#(
    parameter int ARCH_BITS = `ARCH_BITS
) (
    input  logic [0:ARCH_BITS-1] word_i,
    input  logic                 dir_i,
    input  logic [1:0]           mode_i,
    input  logic                 carry_i,
    output logic [0:ARCH_BITS-1] word_o,
    output logic                 carry_o
);

    logic                 w_out;
    logic                 w_fill;
    logic [0:ARCH_BITS-1] w_right;
    logic [0:ARCH_BITS-1] w_left;

    assign w_out = dir_i ? word_i[0] : word_i[ARCH_BITS-1];

    always_comb begin
        w_fill = 1'b0;
        case (mode_i)
            JSH_LOGICAL: w_fill = 1'b0;
            JSH_RCARRY:  w_fill = carry_i;
            JSH_ROT:     w_fill = w_out;
            JSH_ARITH:   w_fill = dir_i ? 1'b0 : word_i[0];
            default:     w_fill = 1'b0;
        endcase
    end

    // Right cells pull from j-1, left cells from j+1; the end cells take the fill bit.
    for (genvar j = 0; j < ARCH_BITS; j++) begin : g_cells
        if (j == 0) begin : g_msb
            assign w_right[j] = w_fill;
        end else begin : g_rmid
            assign w_right[j] = word_i[j-1];
        end
        if (j == ARCH_BITS - 1) begin : g_lsb
            assign w_left[j] = w_fill;
        end else begin : g_lmid
            assign w_left[j] = word_i[j+1];
        end
    end

    assign word_o  = dir_i ? w_left : w_right;
    assign carry_o = w_out;

endmodule

`default_nettype wire

// File: rtl/jshift_seq.sv
// ============================================================================
//  Module   : jshift_seq
//  Brief    : Multi-cycle shift/rotate unit, one bit per clock, start/done handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module jshift_seq
    import jshift_seq_pkg::*;
#(
    parameter int ARCH_BITS = `ARCH_BITS,
    parameter int CNT_BITS  = jsh_cnt_bits(ARCH_BITS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 dir,
    input  logic [1:0]           mode,
    input  logic [CNT_BITS-1:0]  count,
    input  logic [0:ARCH_BITS-1] data_in,
    input  logic                 ci,
    output logic                 busy,
    output logic                 done,
    output logic [0:ARCH_BITS-1] data_out,
    output logic                 co,
    output logic                 zero
);

    logic [1:0]           state_q, state_d;
    logic [CNT_BITS-1:0]  rem_q,   rem_d;
    logic [0:ARCH_BITS-1] data_q,  data_d;
    logic                 co_q,    co_d;
    logic                 dir_q,   dir_d;
    logic [1:0]           mode_q,  mode_d;

    logic [0:ARCH_BITS-1] w_step_word;
    logic                 w_step_carry;

    jshift_step #(
        .ARCH_BITS (ARCH_BITS)
    ) u_step (
        .word_i  (data_q),
        .dir_i   (dir_q),
        .mode_i  (mode_q),
        .carry_i (co_q),
        .word_o  (w_step_word),
        .carry_o (w_step_carry)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = data_q;
        co_d    = co_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    co_d    = ci;
                    dir_d   = dir;
                    mode_d  = mode;
                    rem_d   = count;
                    state_d = (count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = w_step_word;
                co_d   = w_step_carry;
                rem_d  = rem_q - 1'b1;
                if (rem_q == CNT_BITS'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset discards any in-flight operation along with its partial result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            data_q  <= '0;
            co_q    <= 1'b0;
            dir_q   <= 1'b0;
            mode_q  <= JSH_LOGICAL;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            co_q    <= co_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = data_q;
    assign co       = co_q;
    assign zero     = ~|data_q;

endmodule

`default_nettype wire

// File: tb/tb_jshift_seq.sv
// ============================================================================
//  Module   : tb_jshift_seq
//  Brief    : Self-checking bench for jshift_seq against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jshift_seq;

    localparam int W  = 8;
    localparam int CB = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic          dir     = 1'b0;
    logic [1:0]    mode    = 2'b00;
    logic [CB-1:0] count   = '0;
    logic [0:W-1]  data_in = '0;
    logic          ci      = 1'b0;
    logic          busy;
    logic          done;
    logic [0:W-1]  data_out;
    logic          co;
    logic          zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jshift_seq #(
        .ARCH_BITS (W),
        .CNT_BITS  (CB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dir      (dir),
        .mode     (mode),
        .count    (count),
        .data_in  (data_in),
        .ci       (ci),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .co       (co),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value-level model: data word treated as an unsigned integer, MSB = index 0.
    function automatic void model(input bit d, input bit [1:0] m, input int n,
                                  input int v_in, input bit c_in,
                                  output int v, output bit c);
        int out_b;
        int fill;
        v = v_in;
        c = c_in;
        for (int s = 0; s < n; s++) begin
            if (!d) begin
                out_b = v % 2;
                case (m)
                    2'd0:    fill = 0;
                    2'd1:    fill = int'(c);
                    2'd2:    fill = out_b;
                    default: fill = v / (1 << (W - 1));
                endcase
                v = v / 2 + fill * (1 << (W - 1));
            end else begin
                out_b = v / (1 << (W - 1));
                fill  = (m == 2'd1) ? int'(c) : (m == 2'd2) ? out_b : 0;
                v     = (v * 2) % (1 << W) + fill;
            end
            c = (out_b != 0);
        end
    endfunction

    task automatic run_op(input bit d, input bit [1:0] m, input int n,
                          input logic [7:0] v, input bit c, input bit spam,
                          input string tag);
        int ev;
        bit ec;
        int cyc;
        int bcyc;
        model(d, m, n, int'(v), c, ev, ec);
        @(posedge clk); #1;
        start   = 1'b1;
        dir     = d;
        mode    = m;
        count   = n[CB-1:0];
        data_in = v;
        ci      = c;
        cyc     = 0;
        bcyc    = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (busy) bcyc++;
            if (!spam) start = 1'b0;
            dir     = 1'($urandom);
            mode    = 2'($urandom);
            count   = CB'($urandom);
            data_in = W'($urandom);
            ci      = 1'($urandom);
        end while (!done && cyc < 40);
        start = 1'b0;
        chk({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        chk({tag, "_busycyc"}, 32'(bcyc), 32'(n + 1));
        chk({tag, "_data"}, 32'(data_out), 32'(ev));
        chk({tag, "_co"}, 32'(co), 32'(ec));
        chk({tag, "_zero"}, 32'(zero), 32'(ev == 0));
        @(posedge clk); #1;
        chk({tag, "_donefall"}, 32'(done), 32'(0));
        chk({tag, "_idle"}, 32'(busy), 32'(0));
        chk({tag, "_hold"}, 32'(data_out), 32'(ev));
    endtask

    initial begin
        bit saw_done;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_data", 32'(data_out), 32'(0));
        chk("rst_co", 32'(co), 32'(0));
        chk("rst_zero", 32'(zero), 32'(1));
        reset_n = 1'b1;

        run_op(1'b0, 2'b00, 3, 8'h96, 1'b1, 1'b0, "lsr");
        chk("lsr_const", 32'(data_out), 32'h12);
        run_op(1'b1, 2'b01, 1, 8'h80, 1'b0, 1'b0, "rcl1");
        chk("rcl1_const", 32'(co), 32'(1));
        run_op(1'b1, 2'b01, 9, 8'h80, 1'b0, 1'b0, "rcl9");
        chk("rcl9_const", 32'(data_out), 32'h80);
        run_op(1'b0, 2'b11, 2, 8'h90, 1'b0, 1'b0, "asr");
        chk("asr_const", 32'(data_out), 32'hE4);
        run_op(1'b1, 2'b11, 1, 8'h90, 1'b0, 1'b0, "asl");
        chk("asl_const", 32'(data_out), 32'h20);
        run_op(1'b0, 2'b00, 0, 8'h5A, 1'b1, 1'b0, "cnt0");
        chk("cnt0_const", 32'(data_out), 32'h5A);
        run_op(1'b0, 2'b10, 1, 8'h01, 1'b0, 1'b0, "ror1");
        chk("ror1_const", 32'(data_out), 32'h80);
        run_op(1'b0, 2'b10, 8, 8'h01, 1'b0, 1'b0, "ror8");
        chk("ror8_const", 32'(data_out), 32'h01);
        run_op(1'b0, 2'b00, 3, 8'h96, 1'b1, 1'b1, "restart");
        chk("restart_const", 32'(data_out), 32'h12);
        run_op(1'b1, 2'b00, 15, 8'hFF, 1'b1, 1'b0, "lsl15");
        run_op(1'b0, 2'b01, 9, 8'hC3, 1'b1, 1'b0, "rcr9");
        chk("rcr9_const", 32'(data_out), 32'hC3);

        // Abort an operation part-way through with reset.
        @(posedge clk); #1;
        start   = 1'b1;
        dir     = 1'b0;
        mode    = 2'b10;
        count   = CB'(10);
        data_in = 8'hA5;
        ci      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_data", 32'(data_out), 32'(0));
        chk("abort_co", 32'(co), 32'(0));
        chk("abort_zero", 32'(zero), 32'(1));
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_nodone", 32'(saw_done), 32'(0));

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 2'($urandom), int'($urandom_range(0, 15)),
                   8'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
